// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift-add-3 iteration per clock. A start/busy/done handshake tells the display side
// when a new packed BCD result is stable. bcd_out only changes on completion or reset, so
// partial iterations are never visible.
module bin_to_bcd_seq #(
    parameter int unsigned BIN_WIDTH = 4,
    parameter int unsigned DIGITS    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(BIN_WIDTH);

    // 10^n, used to prove the digit count covers the full binary range.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam longint unsigned DecRange = pow10(DIGITS);
    localparam longint unsigned BinMax   = (64'd1 << BIN_WIDTH) - 64'd1;

    if (BIN_WIDTH == 0 || BIN_WIDTH > 16) begin : g_bad_width
        $error("bin_to_bcd_seq: BIN_WIDTH must be in 1..16");
    end

    if (DecRange <= BinMax) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small to hold 2^BIN_WIDTH-1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [BIN_WIDTH-1:0]  bin_q, bin_d;
    logic [BcdW-1:0]       acc_q, acc_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [BcdW-1:0]       acc_adj;
    logic [BcdW-1:0]       acc_step;

    // One double-dabble iteration: add-3 correction per digit, then shift in the binary MSB.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            // 4-bit add: a corrected digit never carries into its neighbour.
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        acc_step    = acc_adj << 1;
        acc_step[0] = bin_q[BIN_WIDTH-1];
    end

    // FSM next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    bin_d   = bin_in;
                    acc_d   = '0;
                    cnt_d   = CntLoad;
                    state_d = StShift;
                end
            end

            StShift: begin
                acc_d = acc_step;
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CntW'(1);
                // Last iteration: publish the fully shifted accumulator in one step.
                if (cnt_q == CntW'(1)) begin
                    bcd_d   = acc_step;
                    state_d = StDone;
                end
            end

            StDone: begin
                // start is deliberately ignored here; the next accept happens from idle.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake flags are registered copies of the next state so they align with it.
    always_comb begin
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State register with synchronous reset; reset discards any in-flight conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

`ifndef SYNTHESIS
    // done is only ever raised inside a conversion.
    done_implies_busy: assert property (@(posedge clk) disable iff (rst) done |-> busy);

    // Every published digit is a legal decimal digit.
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit_chk
        digit_legal: assert property (@(posedge clk) disable iff (rst)
                                      bcd_out[4*g +: 4] <= 4'd9);
    end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 4-bit/2-digit and an 8-bit/3-digit instance share clock and reset.
// A timestamp-based model predicts busy/done/bcd_out every cycle; directed tests pin the model
// with hand-computed values, then a randomized phase stresses both instances.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [3:0]  bin_a   = '0;
    logic        busy_a, done_a;
    logic [7:0]  bcd_a;

    logic        start_b = 1'b0;
    logic [7:0]  bin_b   = '0;
    logic        busy_b, done_b;
    logic [11:0] bcd_b;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bin_to_bcd_seq #(.BIN_WIDTH(4), .DIGITS(2)) u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .bin_in  (bin_a),
        .busy    (busy_a),
        .done    (done_a),
        .bcd_out (bcd_a)
    );

    bin_to_bcd_seq #(.BIN_WIDTH(8), .DIGITS(3)) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .bin_in  (bin_b),
        .busy    (busy_b),
        .done    (done_b),
        .bcd_out (bcd_b)
    );

    // Model state per instance: accept timestamp, captured value, predicted outputs.
    bit          m_have[2];
    int          m_acc_cyc[2];
    int          m_val[2];
    logic [11:0] m_bcd[2];
    logic        m_busy[2];
    logic        m_done[2];

    // Decimal digits by plain arithmetic.
    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        int          v;
        r = '0;
        v = n;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Accepted at edge a: busy after edges a..a+w, done and result after edge a+w.
    task automatic model_step(input int idx, input int w, input logic s, input int b);
        if (rst) begin
            m_have[idx] = 1'b0;
            m_busy[idx] = 1'b0;
            m_done[idx] = 1'b0;
            m_bcd[idx]  = '0;
        end else begin
            m_done[idx] = m_have[idx] && (cyc == m_acc_cyc[idx] + w);
            if (m_done[idx]) m_bcd[idx] = to_bcd(m_val[idx]);
            if (s && !m_busy[idx]) begin
                m_have[idx]    = 1'b1;
                m_acc_cyc[idx] = cyc;
                m_val[idx]     = b;
            end
            m_busy[idx] = m_have[idx] && (cyc <= m_acc_cyc[idx] + w);
        end
    endtask

    task automatic check(input string name, input int idx, input logic busy,
                         input logic done, input logic [11:0] bcd);
        bit bad;
        n_assert++;
        if (busy !== m_busy[idx]) begin
            n_fail++;
            $display("FAIL %s_busy cyc %0d: got %b want %b", name, cyc, busy, m_busy[idx]);
        end
        n_assert++;
        if (done !== m_done[idx]) begin
            n_fail++;
            $display("FAIL %s_done cyc %0d: got %b want %b", name, cyc, done, m_done[idx]);
        end
        n_assert++;
        if (bcd !== m_bcd[idx]) begin
            n_fail++;
            $display("FAIL %s_bcd cyc %0d: got %h want %h", name, cyc, bcd, m_bcd[idx]);
        end
        bad = $isunknown(bcd);
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s_digit_range cyc %0d: got %h want all digits <= 9", name, cyc, bcd);
        end
    endtask

    task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Compare process: advance the model on each edge, compare outputs just after it.
    always @(posedge clk) begin
        cyc++;
        model_step(0, 4, start_a, int'(bin_a));
        model_step(1, 8, start_b, int'(bin_b));
        #1;
        check("a", 0, busy_a, done_a, {4'b0, bcd_a});
        check("b", 1, busy_b, done_b, bcd_b);
    end

    // One-cycle start pulse, bounded wait for done, then one more edge back to idle.
    task automatic conv(input int which, input int v, output int lat, output logic [11:0] res);
        logic got;
        @(negedge clk);
        if (which == 0) begin
            start_a = 1'b1;
            bin_a   = 4'(v);
        end else begin
            start_b = 1'b1;
            bin_b   = 8'(v);
        end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            @(posedge clk);
            #2;
            lat++;
            got = (which == 0) ? done_a : done_b;
        end
        res = (which == 0) ? {4'b0, bcd_a} : bcd_b;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int          lat;
        logic [11:0] res;
        int          nd;
        int          t1, t2;
        logic [11:0] r1, r2;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        expect_eq("idle_bcd", 32'(bcd_a), 32'h0);
        expect_eq("idle_busy", 32'(busy_a), 32'h0);

        // Single conversion of 15: done exactly 4 edges after accept.
        conv(0, 15, lat, res);
        expect_eq("conv15_latency", 32'(lat), 32'd4);
        expect_eq("conv15_bcd", 32'(res), 32'h15);
        expect_eq("conv15_busy_after", 32'(busy_a), 32'h0);
        expect_eq("conv15_done_after", 32'(done_a), 32'h0);

        // Full sweep of the 4-bit range.
        for (int v = 0; v < 16; v++) begin
            conv(0, v, lat, res);
            expect_eq("sweep_bcd", 32'(res), 32'(((v / 10) << 4) | (v % 10)));
            expect_eq("sweep_latency", 32'(lat), 32'd4);
        end

        // start held for 12 cycles; bin_in changes after the first accept.
        nd = 0;
        t1 = -1;
        t2 = -1;
        r1 = '1;
        r2 = '1;
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 4'd9;
        @(posedge clk);
        @(negedge clk);
        bin_a = 4'd3;
        for (int t = 1; t <= 14; t++) begin
            @(posedge clk);
            #2;
            if (done_a) begin
                nd++;
                if (nd == 1) begin
                    t1 = t;
                    r1 = {4'b0, bcd_a};
                end else begin
                    t2 = t;
                    r2 = {4'b0, bcd_a};
                end
            end
            if (t == 11) begin
                @(negedge clk);
                start_a = 1'b0;
            end
        end
        expect_eq("held_done_count", 32'(nd), 32'd2);
        expect_eq("held_first_time", 32'(t1), 32'd4);
        expect_eq("held_first_bcd", 32'(r1), 32'h09);
        expect_eq("held_second_time", 32'(t2), 32'd10);
        expect_eq("held_second_bcd", 32'(r2), 32'h03);

        // Reset at edge k+2 aborts a conversion of 15.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 4'd15;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        expect_eq("abort_bcd", 32'(bcd_a), 32'h0);
        expect_eq("abort_busy", 32'(busy_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (6) begin
            @(posedge clk);
            #2;
            if (done_a) nd++;
        end
        expect_eq("abort_no_done", 32'(nd), 32'd0);
        conv(0, 7, lat, res);
        expect_eq("after_abort_latency", 32'(lat), 32'd4);
        expect_eq("after_abort_bcd", 32'(res), 32'h07);

        // Wide instance.
        conv(1, 255, lat, res);
        expect_eq("wide255_latency", 32'(lat), 32'd8);
        expect_eq("wide255_bcd", 32'(res), 32'h255);
        conv(1, 100, lat, res);
        expect_eq("wide100_bcd", 32'(res), 32'h100);

        // Randomized traffic with occasional resets; the compare process checks every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start_a = ($urandom_range(3) == 0);
            bin_a   = 4'($urandom);
            start_b = ($urandom_range(3) == 0);
            bin_b   = 8'($urandom);
            rst     = ($urandom_range(59) == 0);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        rst     = 1'b0;
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
